sys_cmd_ctrl: RTL
=================

# sys_cmd_ctrl

Command sequencer between the UART receiver and the register-file/ALU/TX-FIFO datapath, all in the reference clock domain. It decodes framed command bytes (0xAA RF write, 0xBB RF read, 0xCC ALU with operands, 0xDD ALU without operands) and drives the register file and ALU, including the ALU clock gate. Results are pushed byte-wise into the async TX FIFO toward the UART transmitter.

## Interface
- DATA_WIDTH, 8, byte width of commands, operands and RF data
- ADDR_WIDTH, 4, register-file address width (16 entries)
- FUN_WIDTH, 4, ALU function code width
- TIMEOUT, 15, max cycles to wait for RF/ALU valid before abort
- CLK  in  1  reference clock; the block's single clock
- RST  in  1  asynchronous, active-low reset
- RX_P_DATA  in  DATA_WIDTH  received byte, synchronized to CLK
- RX_D_VLD  in  1  one-cycle pulse, RX_P_DATA valid
- RF_WR_EN  out  1  RF write strobe
- RF_RD_EN  out  1  RF read strobe
- RF_ADDR  out  ADDR_WIDTH  RF address
- RF_WR_DATA  out  DATA_WIDTH  RF write data
- RF_RD_DATA  in  DATA_WIDTH  RF read data
- RF_RD_DATA_VLD  in  1  RF read data valid
- ALU_EN  out  1  ALU start strobe
- ALU_FUN  out  FUN_WIDTH  ALU function
- ALU_OUT  in  2*DATA_WIDTH  ALU result
- ALU_OUT_VLD  in  1  ALU result valid
- CLK_GATE_EN  out  1  ALU clock-gate enable
- FIFO_WR_DATA  out  DATA_WIDTH  byte to TX FIFO
- FIFO_WR_INC  out  1  FIFO push strobe
- FIFO_FULL  in  1  TX FIFO full
- CMD_ERR  out  1  one-cycle pulse: unknown opcode or timeout

## Operation
- All outputs registered; reset value 0 for every output; state IDLE; timeout counter 0.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUN, GATE, ALU_WAIT, PUSH_LO, PUSH_HI.
- IDLE: on RX_D_VLD, 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->OP_A, 0xDD->FUN; any other byte -> CMD_ERR pulse, stay IDLE.
- WR_ADDR: latch RX_P_DATA[ADDR_WIDTH-1:0] -> WR_DATA. WR_DATA: on byte, RF_WR_EN pulse with latched address/data -> IDLE.
- RD_ADDR: on byte, RF_RD_EN pulse -> RD_WAIT. RD_WAIT: on RF_RD_DATA_VLD capture byte into result low -> PUSH_HI skipped path (single-byte push: PUSH_LO then IDLE).
- OP_A: on byte, RF_WR_EN to address 0 -> OP_B; OP_B: write address 1 -> FUN.
- FUN: on byte, latch ALU_FUN -> GATE (CLK_GATE_EN=1). GATE: ALU_EN pulse, CLK_GATE_EN held -> ALU_WAIT. ALU_WAIT: on ALU_OUT_VLD capture 16 bits, CLK_GATE_EN=0 -> PUSH_LO.
- PUSH_LO: drive FIFO_WR_DATA=low byte, FIFO_WR_INC only when FIFO_FULL=0; then PUSH_HI (ALU) or IDLE (RF read). PUSH_HI: same with high byte -> IDLE.
- RX_D_VLD in RD_WAIT, GATE, ALU_WAIT, PUSH_*: byte dropped, no error.
- Timeout: counter runs in RD_WAIT/ALU_WAIT; reaching TIMEOUT without valid -> CMD_ERR, CLK_GATE_EN=0, IDLE. Counter clears on entering either state.
- Reset mid-command: everything aborts, no partial strobes; CLK_GATE_EN drops asynchronously.

## Timing
- Byte-accept to RF_WR_EN/RF_RD_EN/state change: 1 cycle; strobes exactly 1 cycle wide.
- FUN byte -> CLK_GATE_EN high next cycle; ALU_EN one cycle after gate rises; gate low cycle after ALU_OUT_VLD.
- RF_RD_DATA_VLD -> FIFO_WR_INC: 1 cycle if FIFO not full; ALU_OUT_VLD -> low push 1 cycle, high push 2 cycles (low byte always first).
- FIFO_FULL stalls push indefinitely (no timeout); push resumes the cycle after FULL deasserts.
- Back-to-back command byte accepted in IDLE the cycle after returning.

## Structure
- Shared package sys_ctrl_pkg: opcode constants (0xAA/0xBB/0xCC/0xDD), state enum, operand addresses (0, 1), timeout width.
- Single module; no sub-module warranted.

## Test plan
- AA,05,AA -> one RF_WR_EN, RF_ADDR=5, RF_WR_DATA=AA; no FIFO push.
- BB,03, RF returns 20 one cycle later -> one FIFO push of 0x20.
- CC,FF,FF,00, ALU_OUT=01FE -> RF writes addr0=FF, addr1=FF; ALU_FUN=0; pushes FE then 01; CLK_GATE_EN spans ALU_EN..ALU_OUT_VLD.
- DD,02 with FIFO_FULL high 5 cycles, ALU_OUT=0004 -> no push while full; then 04, 00 on consecutive free cycles.
- Byte 0x55 in IDLE -> CMD_ERR pulse, stays IDLE; BB,02 with no RF_RD_DATA_VLD -> CMD_ERR after 15 cycles, IDLE.
- RST low during ALU_WAIT -> all outputs 0 immediately; next DD command processed normally.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// rtl/sys_ctrl_pkg.sv - shared opcodes, state encodings and constants for the command sequencer
package sys_ctrl_pkg;

  localparam logic [7:0] OP_RF_WR   = 8'hAA;
  localparam logic [7:0] OP_RF_RD   = 8'hBB;
  localparam logic [7:0] OP_ALU_OPS = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE     = 4'd0;
  localparam state_t S_WR_ADDR  = 4'd1;
  localparam state_t S_WR_DATA  = 4'd2;
  localparam state_t S_RD_ADDR  = 4'd3;
  localparam state_t S_RD_WAIT  = 4'd4;
  localparam state_t S_OP_A     = 4'd5;
  localparam state_t S_OP_B     = 4'd6;
  localparam state_t S_FUN      = 4'd7;
  localparam state_t S_GATE     = 4'd8;
  localparam state_t S_ALU_WAIT = 4'd9;
  localparam state_t S_PUSH_LO  = 4'd10;
  localparam state_t S_PUSH_HI  = 4'd11;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  localparam int TMO_W = 4;

endpackage

// File: rtl/sys_cmd_ctrl.sv
// rtl/sys_cmd_ctrl.sv - UART command sequencer driving register file, ALU and TX FIFO
module sys_cmd_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
  input  logic                      RX_D_VLD,
  output logic                      RF_WR_EN,
  output logic                      RF_RD_EN,
  output logic [ADDR_WIDTH-1:0]     RF_ADDR,
  output logic [DATA_WIDTH-1:0]     RF_WR_DATA,
  input  logic [DATA_WIDTH-1:0]     RF_RD_DATA,
  input  logic                      RF_RD_DATA_VLD,
  output logic                      ALU_EN,
  output logic [FUN_WIDTH-1:0]      ALU_FUN,
  input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
  input  logic                      ALU_OUT_VLD,
  output logic                      CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]     FIFO_WR_DATA,
  output logic                      FIFO_WR_INC,
  input  logic                      FIFO_FULL,
  output logic                      CMD_ERR
);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [2*DATA_WIDTH-1:0] result;
  logic                    is_alu;
  logic [TMO_W-1:0]        tcnt;

  localparam logic [TMO_W-1:0] TCNT_LAST = TMO_W'(TIMEOUT - 1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= S_IDLE;
      wr_addr      <= '0;
      result       <= '0;
      is_alu       <= 1'b0;
      tcnt         <= '0;
      RF_WR_EN     <= 1'b0;
      RF_RD_EN     <= 1'b0;
      RF_ADDR      <= '0;
      RF_WR_DATA   <= '0;
      ALU_EN       <= 1'b0;
      ALU_FUN      <= '0;
      CLK_GATE_EN  <= 1'b0;
      FIFO_WR_DATA <= '0;
      FIFO_WR_INC  <= 1'b0;
      CMD_ERR      <= 1'b0;
    end else begin
      RF_WR_EN    <= 1'b0;
      RF_RD_EN    <= 1'b0;
      ALU_EN      <= 1'b0;
      FIFO_WR_INC <= 1'b0;
      CMD_ERR     <= 1'b0;

      case (state)
        S_IDLE: begin
          if (RX_D_VLD) begin
            case (RX_P_DATA)
              OP_RF_WR:   state <= S_WR_ADDR;
              OP_RF_RD:   state <= S_RD_ADDR;
              OP_ALU_OPS: state <= S_OP_A;
              OP_ALU_NOP: state <= S_FUN;
              default:    CMD_ERR <= 1'b1;
            endcase
          end
        end

        S_WR_ADDR: begin
          if (RX_D_VLD) begin
            wr_addr <= RX_P_DATA[ADDR_WIDTH-1:0];
            state   <= S_WR_DATA;
          end
        end

        S_WR_DATA: begin
          if (RX_D_VLD) begin
            RF_WR_EN   <= 1'b1;
            RF_ADDR    <= wr_addr;
            RF_WR_DATA <= RX_P_DATA;
            state      <= S_IDLE;
          end
        end

        S_RD_ADDR: begin
          if (RX_D_VLD) begin
            RF_RD_EN <= 1'b1;
            RF_ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
            is_alu   <= 1'b0;
            tcnt     <= '0;
            state    <= S_RD_WAIT;
          end
        end

        // A free FIFO takes the byte straight from the valid cycle; otherwise PUSH_LO waits.
        S_RD_WAIT: begin
          if (RF_RD_DATA_VLD) begin
            result[DATA_WIDTH-1:0] <= RF_RD_DATA;
            if (!FIFO_FULL) begin
              FIFO_WR_DATA <= RF_RD_DATA;
              FIFO_WR_INC  <= 1'b1;
              state        <= S_IDLE;
            end else begin
              state <= S_PUSH_LO;
            end
          end else if (tcnt == TCNT_LAST) begin
            CMD_ERR <= 1'b1;
            state   <= S_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        S_OP_A: begin
          if (RX_D_VLD) begin
            RF_WR_EN   <= 1'b1;
            RF_ADDR    <= ADDR_WIDTH'(OPA_ADDR);
            RF_WR_DATA <= RX_P_DATA;
            state      <= S_OP_B;
          end
        end

        S_OP_B: begin
          if (RX_D_VLD) begin
            RF_WR_EN   <= 1'b1;
            RF_ADDR    <= ADDR_WIDTH'(OPB_ADDR);
            RF_WR_DATA <= RX_P_DATA;
            state      <= S_FUN;
          end
        end

        S_FUN: begin
          if (RX_D_VLD) begin
            ALU_FUN     <= RX_P_DATA[FUN_WIDTH-1:0];
            CLK_GATE_EN <= 1'b1;
            is_alu      <= 1'b1;
            state       <= S_GATE;
          end
        end

        // One cycle of gated clock before the start strobe lets the ALU clock settle.
        S_GATE: begin
          ALU_EN <= 1'b1;
          tcnt   <= '0;
          state  <= S_ALU_WAIT;
        end

        S_ALU_WAIT: begin
          if (ALU_OUT_VLD) begin
            result      <= ALU_OUT;
            CLK_GATE_EN <= 1'b0;
            if (!FIFO_FULL) begin
              FIFO_WR_DATA <= ALU_OUT[DATA_WIDTH-1:0];
              FIFO_WR_INC  <= 1'b1;
              state        <= S_PUSH_HI;
            end else begin
              state <= S_PUSH_LO;
            end
          end else if (tcnt == TCNT_LAST) begin
            CMD_ERR     <= 1'b1;
            CLK_GATE_EN <= 1'b0;
            state       <= S_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        S_PUSH_LO: begin
          if (!FIFO_FULL) begin
            FIFO_WR_DATA <= result[DATA_WIDTH-1:0];
            FIFO_WR_INC  <= 1'b1;
            state        <= is_alu ? S_PUSH_HI : S_IDLE;
          end
        end

        S_PUSH_HI: begin
          if (!FIFO_FULL) begin
            FIFO_WR_DATA <= result[2*DATA_WIDTH-1:DATA_WIDTH];
            FIFO_WR_INC  <= 1'b1;
            state        <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
